// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Types and constants shared by the RV32I pipeline stages.
//   ctrl_t      : packed decode control bundle carried from Decode to Execute
//   CTRL_BUBBLE : control bundle of an inserted no-op (also the reset value)
//   bubbleOf()  : clears the architecturally visible fields of a bundle and
//                 keeps the don't-care fields, as the ID/EX register does
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [2:0] BRANCH_NONE    = 3'h2;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       aluSrc;
        logic       jalr;
        logic [1:0] resultSrc;
        logic [1:0] storeType;
        logic [2:0] loadType;
        logic [2:0] branchType;
        logic [3:0] aluControl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regWrite   : 1'b0,
        memWrite   : 1'b0,
        jump       : 1'b0,
        branch     : 1'b0,
        aluSrc     : 1'b0,
        jalr       : 1'b0,
        resultSrc  : 2'b00,
        storeType  : 2'b00,
        loadType   : 3'h0,
        branchType : BRANCH_NONE,
        aluControl : 4'h0
    };

    // Turn a decoded bundle into a bubble: every field that can cause a side
    // effect or a forwarding match is forced, the rest pass through so the
    // bubble path needs no extra muxing on them.
    function automatic ctrl_t bubbleOf(input ctrl_t d);
        ctrl_t b;
        b            = d;
        b.regWrite   = 1'b0;
        b.memWrite   = 1'b0;
        b.jump       = 1'b0;
        b.branch     = 1'b0;
        b.jalr       = 1'b0;
        b.resultSrc  = 2'b00;
        b.branchType = BRANCH_NONE;
        return b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use hazard detector.
//   Ports:
//     RdE, ResultSrcE, ValidE : instruction currently in Execute
//     Rs1D, Rs2D              : source registers of the instruction in Decode
//     lwStall                 : Decode must wait one cycle for the load data
//   Both source indices are compared even if the instruction has no rs2; the
//   occasional false stall is cheaper than decoding operand usage here.
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       ValidE,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    output logic       lwStall
);

    // A load in Execute whose destination is read in Decode; x0 never
    // carries a dependency and an invalid (flushed) slot never stalls.
    always_comb begin
        lwStall = ValidE
                & (ResultSrcE == RESULT_SRC_MEM)
                & (RdE != 5'd0)
                & ((RdE == Rs1D) | (RdE == Rs2D));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-Execute pipeline register with load-use stall and branch flush.
//   Ports:
//     clk, rst_n               : clock, asynchronous active-low reset
//     *D inputs                : decode control bundle, operands, PCs, indices
//     PCSrcE                   : taken branch/jump resolved in Execute
//     HoldE                    : data-memory wait, freezes front end and stage
//     *E outputs               : registered copies of the *D inputs
//     ValidE                   : Execute slot holds a real instruction
//     StallF, StallD, FlushD   : combinational front-end control
//   Optional feature (macro HAZARD_STATS_EN):
//     StallCnt, FlushCnt       : 32-bit wrapping counters of load-use bubbles
//                                and branch flushes
// ---------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            AluSrcD,
    input  logic            JalrD,
    input  logic [1:0]      ResultSrcD,
    input  logic [1:0]      StoreTypeD,
    input  logic [2:0]      LoadTypeD,
    input  logic [2:0]      BranchTypeD,
    input  logic [3:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            PCSrcE,
    input  logic            HoldE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            AluSrcE,
    output logic            JalrE,
    output logic [1:0]      ResultSrcE,
    output logic [1:0]      StoreTypeE,
    output logic [2:0]      LoadTypeE,
    output logic [2:0]      BranchTypeE,
    output logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     StallCnt,
    output logic [31:0]     FlushCnt
`endif
);

    ctrl_t ctrlD;
    ctrl_t ctrlE;
    logic  lwStall;
    logic  loadBubble;

    // Gather the loose decode control inputs into one bundle.
    always_comb begin
        ctrlD            = CTRL_BUBBLE;
        ctrlD.regWrite   = RegWriteD;
        ctrlD.memWrite   = MemWriteD;
        ctrlD.jump       = JumpD;
        ctrlD.branch     = BranchD;
        ctrlD.aluSrc     = AluSrcD;
        ctrlD.jalr       = JalrD;
        ctrlD.resultSrc  = ResultSrcD;
        ctrlD.storeType  = StoreTypeD;
        ctrlD.loadType   = LoadTypeD;
        ctrlD.branchType = BranchTypeD;
        ctrlD.aluControl = ALUControlD;
    end

    hazard_detect u_hazard_detect (
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .ValidE     (ValidE),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .lwStall    (lwStall)
    );

    // Front-end control. A flush during a memory hold is deferred: the
    // branch stays in Execute and reasserts PCSrcE once the hold drops.
    always_comb begin
        loadBubble = PCSrcE | lwStall;
        StallF     = lwStall | HoldE;
        StallD     = lwStall | HoldE;
        FlushD     = PCSrcE & ~HoldE;
    end

    // ID/EX register. Hold freezes everything; otherwise a bubble replaces
    // the decode instruction on a flush or load-use stall. RdE is cleared in
    // a bubble so forwarding can never match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrlE    <= CTRL_BUBBLE;
            RdE      <= '0;
            ValidE   <= 1'b0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
        end else if (!HoldE) begin
            if (loadBubble) begin
                ctrlE  <= bubbleOf(ctrlD);
                RdE    <= '0;
                ValidE <= 1'b0;
            end else begin
                ctrlE  <= ctrlD;
                RdE    <= RdD;
                ValidE <= 1'b1;
            end
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
        end
    end

    // Unpack the registered bundle onto the individual Execute outputs.
    always_comb begin
        RegWriteE   = ctrlE.regWrite;
        MemWriteE   = ctrlE.memWrite;
        JumpE       = ctrlE.jump;
        BranchE     = ctrlE.branch;
        AluSrcE     = ctrlE.aluSrc;
        JalrE       = ctrlE.jalr;
        ResultSrcE  = ctrlE.resultSrc;
        StoreTypeE  = ctrlE.storeType;
        LoadTypeE   = ctrlE.loadType;
        BranchTypeE = ctrlE.branchType;
        ALUControlE = ctrlE.aluControl;
    end

`ifdef HAZARD_STATS_EN
    // Hazard statistics. A stall coinciding with a flush is counted only as
    // a flush, since the stalled instruction is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= 32'd0;
            FlushCnt <= 32'd0;
        end else begin
            if (lwStall & ~HoldE & ~PCSrcE) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (PCSrcE & ~HoldE) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed self-checking bench for id_ex_stage. Inputs change 1 time unit
//   after a rising edge; outputs are sampled before the next rising edge.
//   Counter checks are compiled in when HAZARD_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD, JalrD;
    logic [1:0]      ResultSrcD, StoreTypeD;
    logic [2:0]      LoadTypeD, BranchTypeD;
    logic [3:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic            PCSrcE, HoldE;
    logic            RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE, JalrE;
    logic [1:0]      ResultSrcE, StoreTypeE;
    logic [2:0]      LoadTypeE, BranchTypeE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            ValidE, StallF, StallD, FlushD;
`ifdef HAZARD_STATS_EN
    logic [31:0]     StallCnt, FlushCnt;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .AluSrcD(AluSrcD), .JalrD(JalrD),
        .ResultSrcD(ResultSrcD), .StoreTypeD(StoreTypeD),
        .LoadTypeD(LoadTypeD), .BranchTypeD(BranchTypeD),
        .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .PCSrcE(PCSrcE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .AluSrcE(AluSrcE), .JalrE(JalrE),
        .ResultSrcE(ResultSrcE), .StoreTypeE(StoreTypeE),
        .LoadTypeE(LoadTypeE), .BranchTypeE(BranchTypeE),
        .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
`ifdef HAZARD_STATS_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decoded instruction on the D inputs; fields not under
    // test get fixed, recognisable values.
    task automatic applyStimulus(input logic rw, input logic [1:0] rs,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] rd1);
        RegWriteD   = rw;
        ResultSrcD  = rs;
        RdD         = rd;
        Rs1D        = rs1;
        Rs2D        = rs2;
        RD1D        = rd1;
        RD2D        = rd1 + 32'd1;
        MemWriteD   = 1'b0;
        JumpD       = 1'b0;
        BranchD     = 1'b0;
        AluSrcD     = 1'b1;
        JalrD       = 1'b0;
        StoreTypeD  = 2'b00;
        LoadTypeD   = 3'h2;
        BranchTypeD = 3'h0;
        ALUControlD = 4'h0;
        ImmExtD     = 32'h4;
        PCD         = 32'h1000;
        PCPlus4D    = 32'h1004;
    endtask

    task automatic test_pass_through();
        applyStimulus(1'b1, 2'b00, 5'd3, 5'd1, 5'd2, 32'd5);
        tick();
        checks++; if (RegWriteE !== 1'b1) begin errors++; $display("[TB] FAIL pass_regwrite got %b want 1", RegWriteE); end
        checks++; if (RdE !== 5'd3) begin errors++; $display("[TB] FAIL pass_rd got %0d want 3", RdE); end
        checks++; if (RD1E !== 32'd5) begin errors++; $display("[TB] FAIL pass_rd1 got %0d want 5", RD1E); end
        checks++; if (ValidE !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid got %b want 1", ValidE); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall got %b want 0", StallD); end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (RegWriteE !== 1'b0) begin errors++; $display("[TB] FAIL rst_regwrite got %b want 0", RegWriteE); end
        checks++; if (MemWriteE !== 1'b0) begin errors++; $display("[TB] FAIL rst_memwrite got %b want 0", MemWriteE); end
        checks++; if (BranchTypeE !== 3'h2) begin errors++; $display("[TB] FAIL rst_btype got %0h want 2", BranchTypeE); end
        checks++; if (RD1E !== 32'd0) begin errors++; $display("[TB] FAIL rst_rd1 got %0d want 0", RD1E); end
        checks++; if (ValidE !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", ValidE); end
        checks++; if (RdE !== 5'd0) begin errors++; $display("[TB] FAIL rst_rd got %0d want 0", RdE); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        applyStimulus(1'b1, 2'b01, 5'd5, 5'd1, 5'd0, 32'h100);
        tick();
        applyStimulus(1'b1, 2'b00, 5'd6, 5'd5, 5'd1, 32'h200);
        #1;
        checks++; if (StallF !== 1'b1) begin errors++; $display("[TB] FAIL lu_stallf got %b want 1", StallF); end
        checks++; if (StallD !== 1'b1) begin errors++; $display("[TB] FAIL lu_stalld got %b want 1", StallD); end
        checks++; if (FlushD !== 1'b0) begin errors++; $display("[TB] FAIL lu_flush got %b want 0", FlushD); end
        tick();
        checks++; if (RdE !== 5'd0) begin errors++; $display("[TB] FAIL lu_bubble_rd got %0d want 0", RdE); end
        checks++; if (RegWriteE !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_rw got %b want 0", RegWriteE); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("[TB] FAIL lu_one_cycle got %b want 0", StallD); end
        tick();
        checks++; if (RdE !== 5'd6) begin errors++; $display("[TB] FAIL lu_add_rd got %0d want 6", RdE); end
        checks++; if (ValidE !== 1'b1) begin errors++; $display("[TB] FAIL lu_add_valid got %b want 1", ValidE); end
        // lw x0 followed by a reader of x0
        applyStimulus(1'b1, 2'b01, 5'd0, 5'd1, 5'd2, 32'h300);
        tick();
        applyStimulus(1'b1, 2'b00, 5'd7, 5'd0, 5'd0, 32'h400);
        #1;
        checks++; if (StallD !== 1'b0) begin errors++; $display("[TB] FAIL x0_stall got %b want 0", StallD); end
        tick();
        checks++; if (RdE !== 5'd7) begin errors++; $display("[TB] FAIL x0_reader_rd got %0d want 7", RdE); end
    endtask

    task automatic test_branch_flush();
        applyStimulus(1'b1, 2'b00, 5'd8, 5'd9, 5'd10, 32'h55);
        PCSrcE = 1'b1;
        #1;
        checks++; if (FlushD !== 1'b1) begin errors++; $display("[TB] FAIL br_flush got %b want 1", FlushD); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("[TB] FAIL br_stall got %b want 0", StallD); end
        tick();
        checks++; if (ValidE !== 1'b0) begin errors++; $display("[TB] FAIL br_valid got %b want 0", ValidE); end
        checks++; if (RdE !== 5'd0) begin errors++; $display("[TB] FAIL br_rd got %0d want 0", RdE); end
        checks++; if (BranchTypeE !== 3'h2) begin errors++; $display("[TB] FAIL br_btype got %0h want 2", BranchTypeE); end
        checks++; if (RD1E !== 32'h55) begin errors++; $display("[TB] FAIL br_data got %0h want 55", RD1E); end
        PCSrcE = 1'b0;
    endtask

    task automatic test_simultaneous();
        applyStimulus(1'b1, 2'b01, 5'd10, 5'd1, 5'd2, 32'h60);
        tick();
        checks++; if (ValidE !== 1'b1) begin errors++; $display("[TB] FAIL sim_lw_valid got %b want 1", ValidE); end
        applyStimulus(1'b1, 2'b00, 5'd11, 5'd10, 5'd3, 32'h61);
        PCSrcE = 1'b1;
        #1;
        checks++; if (FlushD !== 1'b1) begin errors++; $display("[TB] FAIL sim_flush got %b want 1", FlushD); end
        checks++; if (StallD !== 1'b1) begin errors++; $display("[TB] FAIL sim_stall got %b want 1", StallD); end
        tick();
        PCSrcE = 1'b0;
        #1;
        checks++; if (ValidE !== 1'b0) begin errors++; $display("[TB] FAIL sim_bubble got %b want 0", ValidE); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("[TB] FAIL sim_no_restall got %b want 0", StallD); end
    endtask

    task automatic test_hold();
        applyStimulus(1'b1, 2'b00, 5'd12, 5'd1, 5'd2, 32'h70);
        tick();
        applyStimulus(1'b1, 2'b00, 5'd13, 5'd1, 5'd2, 32'h71);
        HoldE  = 1'b1;
        PCSrcE = 1'b1;
        #1;
        checks++; if (FlushD !== 1'b0) begin errors++; $display("[TB] FAIL hold_flush got %b want 0", FlushD); end
        checks++; if (StallF !== 1'b1) begin errors++; $display("[TB] FAIL hold_stallf got %b want 1", StallF); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (RdE !== 5'd12 || ValidE !== 1'b1 || RD1E !== 32'h70)
                begin errors++; $display("[TB] FAIL hold_frozen cycle %0d got rd=%0d v=%b rd1=%0h want rd=12 v=1 rd1=70", i, RdE, ValidE, RD1E); end
        end
        HoldE = 1'b0;
        #1;
        checks++; if (FlushD !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_flush got %b want 1", FlushD); end
        tick();
        checks++; if (ValidE !== 1'b0 || RdE !== 5'd0) begin errors++; $display("[TB] FAIL hold_release_bubble got v=%b rd=%0d want v=0 rd=0", ValidE, RdE); end
        PCSrcE = 1'b0;
    endtask

    task automatic test_stats();
`ifdef HAZARD_STATS_EN
        checks++; if (StallCnt !== 32'd1) begin errors++; $display("[TB] FAIL stall_cnt got %0d want 1", StallCnt); end
        checks++; if (FlushCnt !== 32'd3) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 3", FlushCnt); end
`endif
    endtask

    task automatic test_reset_in_hold();
        applyStimulus(1'b1, 2'b00, 5'd14, 5'd1, 5'd2, 32'h80);
        HoldE = 1'b1;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        checks++; if (ValidE !== 1'b0 || RdE !== 5'd0) begin errors++; $display("[TB] FAIL rsthold_frozen got v=%b rd=%0d want v=0 rd=0", ValidE, RdE); end
        HoldE = 1'b0;
        tick();
        checks++; if (ValidE !== 1'b1 || RdE !== 5'd14) begin errors++; $display("[TB] FAIL rsthold_release got v=%b rd=%0d want v=1 rd=14", ValidE, RdE); end
    endtask

    // Scenario sequence. Counter expectations assume the reset in
    // test_reset and the hazards of the scenarios that follow it.
    initial begin
        rst_n  = 1'b0;
        PCSrcE = 1'b0;
        HoldE  = 1'b0;
        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
        #12 rst_n = 1'b1;
        tick();
        test_pass_through();
        test_reset();
        test_load_use();
        test_branch_flush();
        test_simultaneous();
        test_hold();
        test_stats();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline boundary for the 5-stage RV32I core. It registers the decode control bundle and operands into the Execute stage. It detects load-use hazards and turns taken branches and jumps into bubbles. It drives the fetch/decode stall and flush lines that gate the PC and IF/ID registers.

## Interface
Parameters:
- XLEN, 32, datapath width for operands, PC and immediate.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD, JalrD  in  1 each  decode control.
- ResultSrcD, StoreTypeD  in  2 each; ImmSrcD unused here; LoadTypeD, BranchTypeD  in  3 each; ALUControlD  in  4.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands and PCs.
- Rs1D, Rs2D, RdD  in  5 each  register indices.
- PCSrcE  in  1  taken branch or jump resolved in Execute, from the branch unit.
- HoldE  in  1  data-memory wait; freezes the front end and this stage.
- Every D control/data/index input above except ImmSrcD has an E-suffixed output of equal width (e.g. RegWriteE, RD1E, RdE).
- ValidE  out  1  Execute slot holds a real instruction.
- StallF, StallD, FlushD  out  1 each  front-end control.

## Operation
- Combinational load-use detect: lwStall = ValidE & (ResultSrcE == 2'b01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Rs1D/Rs2D are compared unconditionally. A false stall on instructions without rs2 is accepted.
- Front-end outputs:
  - StallF = StallD = lwStall | HoldE.
  - FlushD = PCSrcE & ~HoldE.
- Register update each edge, priority high to low:
  1. HoldE=1: all E registers keep their value.
  2. PCSrcE=1 or lwStall=1: load a bubble.
  3. Otherwise: load all D inputs and set ValidE=1.
- Bubble contents:
  - RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ValidE = 0.
  - BranchTypeE = 3'h2 (no-branch); ResultSrcE = 0; RdE = 0, so forwarding never matches a bubble.
  - Data fields (RD1E, RD2E, ImmExtE, PCs, Rs1E, Rs2E) and the remaining control fields still load their D values; they are don't-care downstream.
- PCSrcE and lwStall together: the bubble wins and FlushD=1. The stalled decode instruction is on the wrong path and is discarded.
- ValidE=0 suppresses lwStall, so a flushed load never stalls.

## Timing
- Latency: one cycle, D inputs to E outputs.
- Reset, asynchronous and immediate: every E output equals the bubble value with all data fields 0. ValidE=0.
- StallF, StallD and FlushD are purely combinational from E state, D indices, HoldE and PCSrcE. Same-cycle paths, no registers.
- A load-use produces exactly one bubble cycle. The next edge moves the load to Memory, so lwStall deasserts.
- Reset deasserted mid-hold: outputs stay at the bubble value until the first edge where HoldE=0.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs StallCnt and FlushCnt, 32 bits each, wrapping.
  - StallCnt increments on each edge where lwStall & ~HoldE & ~PCSrcE.
  - FlushCnt increments on each edge where PCSrcE & ~HoldE.
  - Both reset to 0.
- HAZARD_STATS_EN not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - ctrl_t: packed struct of the decode control bundle.
  - CTRL_BUBBLE: constant ctrl_t.
  - RESULT_SRC_MEM = 2'b01, BRANCH_NONE = 3'h2.
  - The control unit adopts ctrl_t later.
- Sub-module hazard_detect: combinational lwStall from RdE, ResultSrcE, ValidE, Rs1D, Rs2D. Instantiated once.

## Test plan
- Reset: drive rst_n low mid-stream -> same cycle RegWriteE=0, MemWriteE=0, BranchTypeE=3'h2, RD1E=0, ValidE=0.
- Pass-through: add x3,x1,x2 (RegWriteD=1, ALUControlD=0, RdD=3, RD1D=5) -> next edge RegWriteE=1, RdE=3, RD1E=5, ValidE=1, no stall.
- Load-use: lw x5 then add x6,x5,x1:
  - StallF=StallD=1 for one cycle.
  - Next edge loads a bubble (RdE=0, RegWriteE=0).
  - The following edge loads the add.
  - lw x0 followed by a reader of x0 -> no stall.
- Branch flush: PCSrcE=1 -> FlushD=1 the same cycle; next edge E is a bubble with ValidE=0.
- Simultaneous: lwStall=1 and PCSrcE=1 -> FlushD=1, StallD=1, bubble loaded, no second stall cycle.
- Hold: HoldE=1 for 3 cycles with PCSrcE=1 -> E outputs frozen, FlushD=0; flush takes effect on the first edge after release. With HAZARD_STATS_EN: StallCnt and FlushCnt match the counts of the prior scenarios.
